// File: rtl/fir_out_decim.sv
// fir_out_decim: keeps one FIR output sample in DECIM, rounds half-up, saturates to
// OUT_W bits and buffers the result in a first-word-fall-through ready/valid FIFO.
module fir_out_decim #(
    parameter int IN_W       = 29,
    parameter int OUT_W      = 12,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    input  logic             clr,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
    output logic [15:0]      sat_cnt
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (SHIFT-1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    // Decimation phase only moves on valid input, so gaps in the stream are transparent.
    logic [PH_W-1:0] ph;
    logic            keep;

    assign keep = din_valid && (ph == '0);

    always_ff @(posedge clk) begin
        if (rst)
            ph <= '0;
        else if (din_valid)
            ph <= (ph == PH_W'(DECIM-1)) ? '0 : ph + PH_W'(1);
    end

    // One guard bit keeps the rounding add from wrapping.
    logic signed [IN_W:0] s, r;
    logic                 sat_hi, sat_lo;
    logic [OUT_W-1:0]     sat_val;

    always_comb begin
        s       = $signed({din[IN_W-1], din}) + HALF;
        r       = s >>> SHIFT;
        sat_hi  = r > MAXV;
        sat_lo  = r < MINV;
        sat_val = r[OUT_W-1:0];
        if (sat_hi)
            sat_val = MAXV[OUT_W-1:0];
        else if (sat_lo)
            sat_val = MINV[OUT_W-1:0];
    end

    logic [OUT_W-1:0] q;
    logic             q_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else begin
            q_vld <= keep;
            if (keep)
                q <= sat_val;
        end
    end

    // Counted at capture time, so samples later lost to overflow are still counted.
    always_ff @(posedge clk) begin
        if (rst || clr)
            sat_cnt <= '0;
        else if (keep && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
    end

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, pop, push, drop;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push       = q_vld && (!full || pop);
    assign drop       = q_vld && full && !pop;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
    end

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: one DECIM=1 and one DECIM=4 instance on shared inputs.
module tb_fir_out_decim;
    localparam int IN_W  = 29;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din_valid = 1'b0;
    logic [IN_W-1:0]  din = '0;
    logic             clr = 1'b0;
    logic             dout_ready = 1'b1;

    logic [OUT_W-1:0] d1_dout, d4_dout;
    logic             d1_dout_valid, d4_dout_valid;
    logic             d1_ovf, d4_ovf;
    logic [15:0]      d1_sat_cnt, d4_sat_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int dq[$];

    always #5 clk = ~clk;

    fir_out_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(4)) u_d1 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
        .dout(d1_dout), .dout_valid(d1_dout_valid), .dout_ready(dout_ready),
        .ovf(d1_ovf), .sat_cnt(d1_sat_cnt)
    );

    fir_out_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(15), .DECIM(4), .FIFO_DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
        .dout(d4_dout), .dout_valid(d4_dout_valid), .dout_ready(dout_ready),
        .ovf(d4_ovf), .sat_cnt(d4_sat_cnt)
    );

    // With dout_ready high every valid cycle is a pop, so each output is seen exactly once.
    always @(negedge clk)
        if (d4_dout_valid && dout_ready)
            dq.push_back(int'($signed(d4_dout)));

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; din_valid = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated sample through the DECIM=1 instance, checking the 2-cycle latency.
    task automatic send1(input string tag, input int v, input int exp);
        @(posedge clk); #1;
        din_valid = 1'b1; din = IN_W'(v);
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, d1_dout_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, d1_dout_valid, 1);
        chk(tag, $signed(d1_dout), exp);
    endtask

    task automatic feed_sparse(input int v);
        @(posedge clk); #1;
        din_valid = 1'b1; din = IN_W'(v * 32768);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_dout", d1_dout, 0);
        chk("rst_vld", d1_dout_valid, 0);
        chk("rst_ovf", d1_ovf, 0);
        chk("rst_sat", d1_sat_cnt, 0);

        // Rounding: half-up at +-0.5 LSB.
        dout_ready = 1'b1;
        send1("rnd_p16384", 16384, 1);
        send1("rnd_p16383", 16383, 0);
        send1("rnd_m16384", -16384, 0);
        send1("rnd_m16385", -16385, -1);
        chk("rnd_sat", d1_sat_cnt, 0);

        // Saturation edges.
        send1("sat_2047", 67076096, 2047);
        chk("sat_cnt0", d1_sat_cnt, 0);
        send1("sat_2048", 67108864, 2047);
        chk("sat_cnt1", d1_sat_cnt, 1);
        send1("sat_m2049", -67141632, -2048);
        chk("sat_cnt2", d1_sat_cnt, 2);
        send1("sat_max", 268435455, 2047);
        chk("sat_cnt3", d1_sat_cnt, 3);

        // Decimation by 4 on a sparse ramp.
        do_reset();
        dq.delete();
        for (int k = 0; k < 16; k++) feed_sparse(k);
        repeat (4) @(posedge clk);
        chk("dec_n", dq.size(), 4);
        for (int i = 0; i < 4 && i < dq.size(); i++) chk($sformatf("dec_%0d", i), dq[i], 4 * i);

        // Reset mid-stream (phase would otherwise be 2).
        for (int k = 0; k < 6; k++) feed_sparse(k);
        do_reset();
        dq.delete();
        for (int k = 20; k < 28; k++) feed_sparse(k);
        repeat (4) @(posedge clk);
        chk("rstm_n", dq.size(), 2);
        if (dq.size() > 0) chk("rstm_0", dq[0], 20);
        if (dq.size() > 1) chk("rstm_1", dq[1], 24);

        // Back-pressure: 5 back-to-back samples into a 4-deep FIFO.
        do_reset();
        dout_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            @(posedge clk); #1;
            din_valid = 1'b1; din = IN_W'(v * 32768);
        end
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        chk("bp_ovf_pre", d1_ovf, 0);
        @(negedge clk);
        chk("bp_ovf", d1_ovf, 1);
        @(posedge clk); #1 dout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_vld_%0d", i), d1_dout_valid, 1);
            chk($sformatf("bp_dout_%0d", i), $signed(d1_dout), i);
        end
        @(negedge clk);
        chk("bp_empty", d1_dout_valid, 0);

        // Full FIFO with a pop in the same cycle as the write.
        do_reset();
        dout_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            @(posedge clk); #1;
            din_valid = 1'b1; din = IN_W'(v * 32768);
        end
        @(posedge clk); #1 din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 din_valid = 1'b1; din = IN_W'(5 * 32768);
        @(posedge clk); #1;
        din_valid = 1'b0; dout_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("fp_dout_%0d", i), $signed(d1_dout), i);
        end
        chk("fp_ovf", d1_ovf, 0);
        @(negedge clk);
        chk("fp_empty", d1_dout_valid, 0);

        // Counter limit, then clr against a coincident saturation and drop.
        do_reset();
        dout_ready = 1'b0;
        @(posedge clk); #1;
        din_valid = 1'b1; din = IN_W'(268435455);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("lim_sat", d1_sat_cnt, 16'hFFFF);
        chk("lim_ovf", d1_ovf, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk("clr_sat", d1_sat_cnt, 0);
        chk("clr_ovf", d1_ovf, 0);
        @(negedge clk);
        chk("clr_ovf_after", d1_ovf, 1);
        chk("clr_sat_after", d1_sat_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
